spi_slave_sync: RTL and testbench
=================================

Name: spi_slave_sync

Overview:
Parameterised SPI slave, successor to the current byte-wide mode-3 slave. All logic runs in the single P_CLK domain: S_CLK, i_SS and i_MOSI are synchronised and edge-detected, so the block has no S_CLK-clocked flops. Adds run-time-independent CPOL/CPHA selection, configurable word width and bit order, a TX holding register with valid/ready handshake, back-to-back words within one SS frame, and underrun/abort reporting. Sits between the SPI pins and the peripheral's register/FIFO logic.

Parameters:
DATA_W, 8, word width in bits (2..32)
CPOL, 1, S_CLK idle level
CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
MSB_FIRST, 1, 1 = MSB shifted first, 0 = LSB first
SYNC_STAGES, 2, synchroniser depth on S_CLK/i_SS/i_MOSI (>=2)

Ports:
P_CLK  input  1  peripheral clock, sole clock
reset  input  1  synchronous, active-low reset
S_CLK  input  1  SPI serial clock (asynchronous)
i_SS  input  1  slave select, active low (asynchronous)
i_MOSI  input  1  master-out data
o_MISO  output  1  slave-out data
o_MISO_OE  output  1  MISO output enable (high while selected)
i_TX_DATA  input  DATA_W  word to transmit
i_TX_VALID  input  1  TX word valid
o_TX_READY  output  1  holding register empty, accept i_TX_DATA
o_RX_DATA  output  DATA_W  last complete received word
o_RX_DV  output  1  one-cycle pulse, o_RX_DATA updated
o_TX_UNDERRUN  output  1  one-cycle pulse, word started with empty holding register
o_FRAME_ERR  output  1  one-cycle pulse, SS deasserted mid-word

Behaviour:
- Reset is sampled on P_CLK only while reset==0. It clears the synchronisers to the idle values (S_CLK=CPOL, SS=1), clears the holding register, and sets the state to IDLE. Outputs during and after reset: o_MISO=0, o_MISO_OE=0, o_TX_READY=1, o_RX_DATA=0, o_RX_DV=0, o_TX_UNDERRUN=0, o_FRAME_ERR=0.
- Synchronisers: SYNC_STAGES flops per input. Edges are detected by comparing the last synced stage with one extra registered copy.
- Leading edge: synced S_CLK leaves CPOL. Trailing edge: synced S_CLK returns to CPOL.
- Sample edge: leading if CPHA=0, trailing if CPHA=1. Shift edge is the other one.
- Timing constraint: the S_CLK half-period must be at least SYNC_STAGES+3 P_CLK cycles. No behaviour is guaranteed below that.
- TX handshake: a write is accepted when i_TX_VALID && o_TX_READY. o_TX_READY drops the next cycle and rises the cycle after the holding register is consumed. There is no bypass: a write accepted in the same cycle as a load is not used by that load.
- States:
  - IDLE: o_MISO_OE=0, o_MISO=0. A synced SS falling edge goes to SHIFT and performs a LOAD.
  - SHIFT: o_MISO_OE=1. A synced SS rising edge returns to IDLE.
- LOAD:
  - If the holding register is full, it is copied into the TX shift register and marked empty.
  - Otherwise the shift register is loaded with zeros and o_TX_UNDERRUN pulses.
  - In all cases the fresh flag is set and the bit counter is cleared.
  - o_MISO always equals the current first-out bit of the TX shift register: MSB if MSB_FIRST, else LSB.
- Shift edge: if fresh=0, the TX shift register advances one bit toward the output. If fresh=1, no shift (first bit held).
- Sample edge:
  - The synced MOSI is shifted into the RX shift register in bit order per MSB_FIRST.
  - fresh is cleared and the bit counter increments.
  - On the DATA_W-th sample, the counter wraps to 0 and the full RX word goes to o_RX_DATA, with o_RX_DV pulsed the next cycle.
  - In the same cycle a LOAD is performed, which gives back-to-back words with no gap.
- Latency: o_RX_DV is high exactly SYNC_STAGES+2 P_CLK cycles after the final sample edge at the pin. o_MISO changes SYNC_STAGES+2 cycles after a shift edge at the pin.
- SS rising edge with bit counter != 0:
  - The partial word is discarded (no o_RX_DV) and o_FRAME_ERR pulses.
  - The TX shift register contents are lost.
  - The holding register is retained.
- SS rising edge with counter==0: clean end, no pulse.
- SS rising and falling in consecutive synced cycles are treated as two independent events.

Test Plan:
1. CPOL=1, CPHA=0, DATA_W=8, MSB_FIRST: write 0xA5, master sends 0x3C over an S_CLK period of 12 P_CLK -> master reads 0xA5; o_RX_DATA=0x3C with a single o_RX_DV pulse; o_TX_READY 1->0->1.
2. All four CPOL/CPHA combinations, DATA_W=16, words 0x1234/0xBEEF in both directions -> bit-exact on both sides for every mode.
3. LSB_FIRST, DATA_W=8: slave TX 0x01, master TX 0x80 -> master's first received bit is 1; o_RX_DATA=0x80.
4. One SS frame of 3 words, holding refilled after each o_TX_READY -> three o_RX_DV pulses, no o_TX_UNDERRUN, MISO words 0x11/0x22/0x33.
5. Frame starts with the holding register empty -> o_TX_UNDERRUN one pulse, master reads 0x00; a later write is used for the next word.
6. SS raised after 5 bits -> o_FRAME_ERR pulse, no o_RX_DV, o_MISO_OE=0; the next full frame is correct. Reset asserted mid-word -> all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/spi_slave_sync.sv
// SPI slave with every input sampled in the P_CLK domain.
// S_CLK, i_SS and i_MOSI each pass through a synchroniser, then an edge detector.
// CPOL, CPHA, word width and bit order are set by parameters.
// A TX holding register with a valid/ready handshake supplies transmit words.
// Several words can follow each other inside one slave-select frame.
module spi_slave_sync #(
  parameter int unsigned DATA_W      = 8,
  parameter bit          CPOL        = 1'b1,
  parameter bit          CPHA        = 1'b0,
  parameter bit          MSB_FIRST   = 1'b1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              P_CLK,
  input  logic              reset,
  input  logic              S_CLK,
  input  logic              i_SS,
  input  logic              i_MOSI,
  output logic              o_MISO,
  output logic              o_MISO_OE,
  input  logic [DATA_W-1:0] i_TX_DATA,
  input  logic              i_TX_VALID,
  output logic              o_TX_READY,
  output logic [DATA_W-1:0] o_RX_DATA,
  output logic              o_RX_DV,
  output logic              o_TX_UNDERRUN,
  output logic              o_FRAME_ERR
);

  localparam int unsigned CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

  // Synchronisers plus one extra copy of each last stage, used for edge detection
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_prev;
  logic                   r_ss_prev;

  // Datapath state
  state_e             r_state;
  logic [DATA_W-1:0]  r_tx_shift;
  logic [DATA_W-1:0]  r_rx_shift;
  logic [DATA_W-1:0]  r_hold;
  logic               r_hold_full;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic               r_fresh;
  logic [DATA_W-1:0]  r_rx_data;
  logic               r_rx_done;
  logic               r_rx_dv;
  logic               r_underrun;
  logic               r_frame_err;
  logic               r_miso;

  // Next-state values and decoded events
  state_e             w_state_next;
  logic [DATA_W-1:0]  w_tx_next;
  logic [DATA_W-1:0]  w_rx_next;
  logic [DATA_W-1:0]  w_hold_next;
  logic               w_hold_full_next;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               w_fresh_next;
  logic [DATA_W-1:0]  w_rx_data_next;
  logic               w_rx_done;
  logic               w_underrun;
  logic               w_frame_err;
  logic               w_load;
  logic               w_miso_next;

  logic w_sclk;
  logic w_ss;
  logic w_mosi;
  logic w_lead;
  logic w_trail;
  logic w_sample_edge;
  logic w_shift_edge;
  logic w_ss_fall;
  logic w_ss_rise;

  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_ss   = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  // Leading edge leaves the idle level; trailing edge returns to it
  assign w_lead        = (r_sclk_prev == CPOL) && (w_sclk != CPOL);
  assign w_trail       = (r_sclk_prev != CPOL) && (w_sclk == CPOL);
  assign w_sample_edge = CPHA ? w_trail : w_lead;
  assign w_shift_edge  = CPHA ? w_lead : w_trail;
  assign w_ss_fall     = r_ss_prev & ~w_ss;
  assign w_ss_rise     = ~r_ss_prev & w_ss;

  // Synchronise the asynchronous pins and keep the previous synced level
  always_ff @(posedge P_CLK) begin
    if (!reset) begin
      r_sclk_sync <= {SYNC_STAGES{CPOL}};
      r_ss_sync   <= {SYNC_STAGES{1'b1}};
      r_mosi_sync <= '0;
      r_sclk_prev <= CPOL;
      r_ss_prev   <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], S_CLK};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_SS};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_MOSI};
      r_sclk_prev <= w_sclk;
      r_ss_prev   <= w_ss;
    end
  end

  // Next-state logic: FSM, shift registers, bit counter, holding register, event pulses
  always_comb begin
    w_state_next     = r_state;
    w_tx_next        = r_tx_shift;
    w_rx_next        = r_rx_shift;
    w_hold_next      = r_hold;
    w_hold_full_next = r_hold_full;
    w_cnt_next       = r_bit_cnt;
    w_fresh_next     = r_fresh;
    w_rx_data_next   = r_rx_data;
    w_rx_done        = 1'b0;
    w_underrun       = 1'b0;
    w_frame_err      = 1'b0;
    w_load           = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (w_ss_fall) begin
          w_state_next = StShift;
          w_load       = 1'b1;
        end
      end
      StShift: begin
        if (w_ss_rise) begin
          // A deselect in the middle of a word drops the word; the holding register is kept
          w_state_next = StIdle;
          w_frame_err  = (r_bit_cnt != '0);
          w_tx_next    = '0;
          w_rx_next    = '0;
          w_cnt_next   = '0;
        end else if (w_sample_edge) begin
          w_rx_next    = MSB_FIRST ? {r_rx_shift[DATA_W-2:0], w_mosi}
                                   : {w_mosi, r_rx_shift[DATA_W-1:1]};
          w_fresh_next = 1'b0;
          if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
            w_cnt_next     = '0;
            w_rx_data_next = w_rx_next;
            w_rx_done      = 1'b1;
            w_load         = 1'b1;
          end else begin
            w_cnt_next = r_bit_cnt + CNT_W'(1);
          end
        end else if (w_shift_edge && !r_fresh) begin
          // While the word is still fresh, its first bit stays on the line
          w_tx_next = MSB_FIRST ? {r_tx_shift[DATA_W-2:0], 1'b0}
                                : {1'b0, r_tx_shift[DATA_W-1:1]};
        end
      end
      default: w_state_next = StIdle;
    endcase

    // Loading uses only what the holding register held before this cycle
    if (w_load) begin
      if (r_hold_full) begin
        w_tx_next        = r_hold;
        w_hold_full_next = 1'b0;
      end else begin
        w_tx_next  = '0;
        w_underrun = 1'b1;
      end
      w_fresh_next = 1'b1;
      w_cnt_next   = '0;
    end

    // A write is accepted only while the holding register is empty, so it never overlaps a drain
    if (i_TX_VALID && !r_hold_full) begin
      w_hold_next      = i_TX_DATA;
      w_hold_full_next = 1'b1;
    end

    w_miso_next = 1'b0;
    if (r_state == StShift) begin
      w_miso_next = MSB_FIRST ? r_tx_shift[DATA_W-1] : r_tx_shift[0];
    end
  end

  // Register the FSM state, datapath and output pulses
  always_ff @(posedge P_CLK) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_tx_shift  <= '0;
      r_rx_shift  <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_bit_cnt   <= '0;
      r_fresh     <= 1'b0;
      r_rx_data   <= '0;
      r_rx_done   <= 1'b0;
      r_rx_dv     <= 1'b0;
      r_underrun  <= 1'b0;
      r_frame_err <= 1'b0;
      r_miso      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_tx_shift  <= w_tx_next;
      r_rx_shift  <= w_rx_next;
      r_hold      <= w_hold_next;
      r_hold_full <= w_hold_full_next;
      r_bit_cnt   <= w_cnt_next;
      r_fresh     <= w_fresh_next;
      r_rx_data   <= w_rx_data_next;
      r_rx_done   <= w_rx_done;
      r_rx_dv     <= r_rx_done;
      r_underrun  <= w_underrun;
      r_frame_err <= w_frame_err;
      r_miso      <= w_miso_next;
    end
  end

  assign o_MISO        = r_miso;
  assign o_MISO_OE     = (r_state == StShift);
  assign o_TX_READY    = ~r_hold_full;
  assign o_RX_DATA     = r_rx_data;
  assign o_RX_DV       = r_rx_dv;
  assign o_TX_UNDERRUN = r_underrun;
  assign o_FRAME_ERR   = r_frame_err;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Scoreboard bench for spi_slave_sync.
// Six instances share one bus-functional SPI master:
//   DUT 0     8-bit, CPOL=1, CPHA=0, MSB first
//   DUTs 1-4  16-bit, one per CPOL/CPHA mode
//   DUT 5     8-bit, LSB first
module tb_spi_slave_sync;

  localparam int H = 6;  // S_CLK half period in P_CLK cycles
  localparam int N = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sclk     [N];
  logic        ss       [N];
  logic        tx_valid [N];
  logic        mosi;
  logic [31:0] tx_data;
  logic        miso [N];
  logic        oe   [N];
  logic        rdy  [N];
  logic        dv   [N];
  logic        und  [N];
  logic        ferr [N];
  logic [7:0]  rxd0;
  logic [7:0]  rxd5;
  logic [15:0] rxdm [4];

  int n_tests  = 0;
  int n_fail   = 0;
  int act      = 0;
  int und_cnt  = 0;
  int ferr_cnt = 0;

  logic [31:0] exp_rx_q[$];
  logic [31:0] exp_miso_q[$];
  logic [31:0] mw_data;
  event        mw_ev;

  spi_slave_sync #(
    .DATA_W(8), .CPOL(1'b1), .CPHA(1'b0), .MSB_FIRST(1'b1), .SYNC_STAGES(2)
  ) u_dut (
    .P_CLK(clk), .reset(rst_n), .S_CLK(sclk[0]), .i_SS(ss[0]), .i_MOSI(mosi),
    .o_MISO(miso[0]), .o_MISO_OE(oe[0]), .i_TX_DATA(tx_data[7:0]), .i_TX_VALID(tx_valid[0]),
    .o_TX_READY(rdy[0]), .o_RX_DATA(rxd0), .o_RX_DV(dv[0]), .o_TX_UNDERRUN(und[0]),
    .o_FRAME_ERR(ferr[0])
  );

  genvar g;
  for (g = 0; g < 4; g++) begin : g_mode
    spi_slave_sync #(
      .DATA_W(16), .CPOL(bit'((g >> 1) & 1)), .CPHA(bit'(g & 1)), .MSB_FIRST(1'b1),
      .SYNC_STAGES(2)
    ) u_dut (
      .P_CLK(clk), .reset(rst_n), .S_CLK(sclk[g+1]), .i_SS(ss[g+1]), .i_MOSI(mosi),
      .o_MISO(miso[g+1]), .o_MISO_OE(oe[g+1]), .i_TX_DATA(tx_data[15:0]),
      .i_TX_VALID(tx_valid[g+1]), .o_TX_READY(rdy[g+1]), .o_RX_DATA(rxdm[g]),
      .o_RX_DV(dv[g+1]), .o_TX_UNDERRUN(und[g+1]), .o_FRAME_ERR(ferr[g+1])
    );
  end

  spi_slave_sync #(
    .DATA_W(8), .CPOL(1'b1), .CPHA(1'b0), .MSB_FIRST(1'b0), .SYNC_STAGES(2)
  ) u_dut_lsb (
    .P_CLK(clk), .reset(rst_n), .S_CLK(sclk[5]), .i_SS(ss[5]), .i_MOSI(mosi),
    .o_MISO(miso[5]), .o_MISO_OE(oe[5]), .i_TX_DATA(tx_data[7:0]), .i_TX_VALID(tx_valid[5]),
    .o_TX_READY(rdy[5]), .o_RX_DATA(rxd5), .o_RX_DV(dv[5]), .o_TX_UNDERRUN(und[5]),
    .o_FRAME_ERR(ferr[5])
  );

  function automatic bit f_cpol(input int id);
    if (id >= 1 && id <= 4) return bit'(((id - 1) >> 1) & 1);
    return 1'b1;
  endfunction

  function automatic bit f_cpha(input int id);
    if (id >= 1 && id <= 4) return bit'((id - 1) & 1);
    return 1'b0;
  endfunction

  function automatic bit f_msb(input int id);
    return id != 5;
  endfunction

  function automatic int f_w(input int id);
    return (id >= 1 && id <= 4) ? 16 : 8;
  endfunction

  function automatic logic [31:0] f_rx(input int id);
    if (id == 0) return {24'h0, rxd0};
    if (id == 5) return {24'h0, rxd5};
    return {16'h0, rxdm[id-1]};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: compare each o_RX_DV word with the queue and count pulses on the active DUT
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (dv[i]) begin
          if (i != act || exp_rx_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rx_dv_unexpected: dut %0d got data %0h expected no pulse", i, f_rx(i));
          end else begin
            check("rx_data", f_rx(i), exp_rx_q.pop_front());
          end
        end
        if (und[i] && i == act) und_cnt++;
        if (ferr[i] && i == act) ferr_cnt++;
      end
    end
  end

  // Monitor: compare each word the master read from MISO with the queue
  always @(mw_ev) begin
    if (exp_miso_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL miso_word_unexpected: got %0h expected none", mw_data);
    end else begin
      check("miso_word", mw_data, exp_miso_q.pop_front());
    end
  end

  task automatic write_hold(input int id, input logic [31:0] d);
    int t;
    t = 0;
    while (!rdy[id] && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!rdy[id]) begin
      n_tests++;
      n_fail++;
      $display("FAIL tx_ready_timeout: dut %0d got 0 expected 1", id);
    end else begin
      tx_data      = d;
      tx_valid[id] = 1'b1;
      @(negedge clk);
      tx_valid[id] = 1'b0;
    end
  endtask

  // Master: clock nbits through DUT id; mi holds the MISO bits, first is the first bit read
  task automatic xfer(input int id, input logic [31:0] mo, input int nbits,
                      output logic [31:0] mi, output logic first);
    int w;
    int idx;
    bit cp;
    bit ph;
    bit msb;
    w     = f_w(id);
    cp    = f_cpol(id);
    ph    = f_cpha(id);
    msb   = f_msb(id);
    mi    = '0;
    first = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      idx = msb ? (w - 1 - i) : i;
      if (!ph) begin
        mosi = mo[idx];
        wait_cyc(H);
        mi[idx]  = miso[id];
        sclk[id] = ~cp;
        wait_cyc(H);
        sclk[id] = cp;
      end else begin
        wait_cyc(H);
        sclk[id] = ~cp;
        mosi     = mo[idx];
        wait_cyc(H);
        mi[idx]  = miso[id];
        sclk[id] = cp;
      end
      if (i == 0) first = mi[idx];
    end
  endtask

  task automatic word(input int id, input logic [31:0] mo);
    logic [31:0] mi;
    logic        f;
    xfer(id, mo, f_w(id), mi, f);
    mw_data = mi;
    ->mw_ev;
  endtask

  task automatic frame_begin(input int id);
    act    = id;
    ss[id] = 1'b0;
    wait_cyc(H);
  endtask

  task automatic frame_end(input int id);
    wait_cyc(H);
    ss[id] = 1'b1;
    wait_cyc(3 * H);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] mi;
    logic        fb;
    int          u0;
    int          f0;
    for (int i = 0; i < N; i++) begin
      sclk[i]     = f_cpol(i);
      ss[i]       = 1'b1;
      tx_valid[i] = 1'b0;
    end
    mosi    = 1'b0;
    tx_data = '0;
    rst_n   = 1'b0;
    wait_cyc(4);
    check("reset_miso", miso[0], 0);
    check("reset_oe", oe[0], 0);
    check("reset_ready", rdy[0], 1);
    check("reset_rx_data", f_rx(0), 0);
    check("reset_rx_dv", dv[0], 0);
    check("reset_underrun", und[0], 0);
    check("reset_frame_err", ferr[0], 0);
    rst_n = 1'b1;
    wait_cyc(2);

    // Test 1: one byte each way; ready goes 1 -> 0 -> 1
    write_hold(0, 32'hA5);
    check("t1_ready_low", rdy[0], 0);
    exp_rx_q.push_back(32'h3C);
    exp_miso_q.push_back(32'hA5);
    u0 = und_cnt;
    frame_begin(0);
    check("t1_ready_high", rdy[0], 1);
    check("t1_oe", oe[0], 1);
    word(0, 32'h3C);
    frame_end(0);
    // The end-of-word reload finds the holding register empty
    check("t1_underrun_cnt", und_cnt - u0, 1);
    check("t1_rx_drained", exp_rx_q.size(), 0);

    // Test 2: the four CPOL/CPHA modes, 16-bit, both directions
    for (int id = 1; id <= 4; id++) begin
      write_hold(id, 32'h1234);
      exp_rx_q.push_back(32'hBEEF);
      exp_miso_q.push_back(32'h1234);
      frame_begin(id);
      word(id, 32'hBEEF);
      frame_end(id);
      write_hold(id, 32'hBEEF);
      exp_rx_q.push_back(32'h1234);
      exp_miso_q.push_back(32'hBEEF);
      frame_begin(id);
      word(id, 32'h1234);
      frame_end(id);
    end

    // Test 3: LSB first
    write_hold(5, 32'h01);
    exp_rx_q.push_back(32'h80);
    exp_miso_q.push_back(32'h01);
    frame_begin(5);
    xfer(5, 32'h80, 8, mi, fb);
    mw_data = mi;
    ->mw_ev;
    frame_end(5);
    check("t3_first_bit", fb, 1);

    // Test 4: three back-to-back words; a fourth refill covers the final reload
    write_hold(0, 32'h11);
    exp_rx_q.push_back(32'hC1);
    exp_rx_q.push_back(32'hC2);
    exp_rx_q.push_back(32'hC3);
    exp_miso_q.push_back(32'h11);
    exp_miso_q.push_back(32'h22);
    exp_miso_q.push_back(32'h33);
    u0 = und_cnt;
    frame_begin(0);
    fork
      begin
        word(0, 32'hC1);
        word(0, 32'hC2);
        word(0, 32'hC3);
      end
      begin
        write_hold(0, 32'h22);
        write_hold(0, 32'h33);
        write_hold(0, 32'h44);
      end
    join
    frame_end(0);
    check("t4_underrun_cnt", und_cnt - u0, 0);
    check("t4_rx_drained", exp_rx_q.size(), 0);

    // Test 5: frame starts with the holding register empty
    exp_rx_q.push_back(32'h5A);
    exp_rx_q.push_back(32'h6B);
    exp_miso_q.push_back(32'h00);
    exp_miso_q.push_back(32'h77);
    u0 = und_cnt;
    frame_begin(0);
    fork
      begin
        word(0, 32'h5A);
        word(0, 32'h6B);
      end
      begin
        wait_cyc(H);
        write_hold(0, 32'h77);
        write_hold(0, 32'h78);
      end
    join
    frame_end(0);
    check("t5_underrun_cnt", und_cnt - u0, 1);

    // Test 6: abort after 5 bits; the holding register written mid-frame survives
    write_hold(0, 32'h99);
    u0 = und_cnt;
    f0 = ferr_cnt;
    frame_begin(0);
    write_hold(0, 32'h5C);
    xfer(0, 32'hFF, 5, mi, fb);
    frame_end(0);
    check("t6_frame_err_cnt", ferr_cnt - f0, 1);
    check("t6_underrun_cnt", und_cnt - u0, 0);
    check("t6_oe_low", oe[0], 0);
    check("t6_no_rx", exp_rx_q.size(), 0);
    check("t6_hold_kept", rdy[0], 0);
    exp_rx_q.push_back(32'hE7);
    exp_miso_q.push_back(32'h5C);
    frame_begin(0);
    word(0, 32'hE7);
    frame_end(0);

    // Reset in the middle of a word
    write_hold(0, 32'h12);
    frame_begin(0);
    xfer(0, 32'hAA, 3, mi, fb);
    rst_n = 1'b0;
    wait_cyc(1);
    check("rst_mid_miso", miso[0], 0);
    check("rst_mid_oe", oe[0], 0);
    check("rst_mid_ready", rdy[0], 1);
    check("rst_mid_rx_data", f_rx(0), 0);
    check("rst_mid_rx_dv", dv[0], 0);
    check("rst_mid_underrun", und[0], 0);
    check("rst_mid_frame_err", ferr[0], 0);
    ss[0] = 1'b1;
    wait_cyc(4);
    rst_n = 1'b1;
    wait_cyc(4);
    check("post_rst_oe", oe[0], 0);

    wait_cyc(10);
    check("final_rx_queue", exp_rx_q.size(), 0);
    check("final_miso_queue", exp_miso_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
